// File: rtl/uart_ram_arbiter_pkg.sv
// uart_ram_arbiter_pkg: shared state/grant encodings and byte-lane helper
package uart_ram_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_RX   = 2'd2
  } arb_state_t;
  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_RX  = 1'b1
  } grant_t;
  function automatic logic [3:0] lane_sel(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction
endpackage

// File: rtl/uart_ram_arbiter_byte_fifo.sv
// byte_fifo: synchronous byte FIFO whose pop frees a slot for a same-cycle push
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;
  assign empty   = level == '0;
  assign full    = level == (AW+1)'(DEPTH);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign dout    = mem[rd_ptr];
  // storage array, written on accepted pushes only
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_ram_arbiter.sv
// uart_ram_arbiter: shares servant_ram between the CPU bus and a UART RX byte ring
module uart_ram_arbiter
  import uart_ram_arbiter_pkg::*;
#(
  parameter logic [31:0] ADR_LL     = 32'h00000C00,
  parameter logic [31:0] ADR_UL     = 32'h00001FFF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          i_wb_clk,
  input  logic                          i_wb_rst,
  input  logic [31:0]                   i_cpu_adr,
  input  logic [31:0]                   i_cpu_dat,
  input  logic [3:0]                    i_cpu_sel,
  input  logic                          i_cpu_we,
  input  logic                          i_cpu_cyc,
  output logic [31:0]                   o_cpu_rdt,
  output logic                          o_cpu_ack,
  input  logic [7:0]                    i_rx_dat,
  input  logic                          i_rx_valid,
  output logic [31:0]                   o_ram_adr,
  output logic [31:0]                   o_ram_dat,
  output logic [3:0]                    o_ram_sel,
  output logic                          o_ram_we,
  output logic                          o_ram_cyc,
  input  logic [31:0]                   i_ram_rdt,
  input  logic                          i_ram_ack,
  output logic [31:0]                   o_rx_ptr,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_level,
  output logic                          o_overflow
);
  arb_state_t state;
  grant_t     last_grant;
  logic [7:0] head;
  logic       full, empty, pop, in_cpu, in_rx;
  assign in_cpu    = state == ARB_CPU;
  assign in_rx     = state == ARB_RX;
  assign pop       = in_rx & i_ram_ack;
  assign o_ram_adr = in_cpu ? i_cpu_adr : in_rx ? o_rx_ptr : '0;
  assign o_ram_dat = in_cpu ? i_cpu_dat : in_rx ? {4{head}} : '0;
  assign o_ram_sel = in_cpu ? i_cpu_sel : in_rx ? lane_sel(o_rx_ptr[1:0]) : '0;
  assign o_ram_we  = in_cpu ? i_cpu_we : in_rx;
  assign o_ram_cyc = in_cpu ? i_cpu_cyc : in_rx;
  assign o_cpu_ack = in_cpu & i_ram_ack;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_wb_clk),
    .rst   (i_wb_rst),
    .push  (i_rx_valid),
    .din   (i_rx_dat),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (o_rx_level)
  );
  // round-robin arbiter FSM; every transaction returns through IDLE so cyc drops between grants
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state      <= ARB_IDLE;
      last_grant <= GNT_RX;
      o_rx_ptr   <= ADR_LL;
      o_overflow <= 1'b0;
      o_cpu_rdt  <= '0;
    end else begin
      if (i_rx_valid & full & !pop) o_overflow <= 1'b1;
      case (state)
        ARB_IDLE:
          if (i_cpu_cyc && (empty || last_grant == GNT_RX)) begin
            state      <= ARB_CPU;
            last_grant <= GNT_CPU;
          end else if (!empty) begin
            state      <= ARB_RX;
            last_grant <= GNT_RX;
          end
        ARB_CPU:
          if (i_ram_ack) begin
            o_cpu_rdt <= i_ram_rdt;
            state     <= ARB_IDLE;
          end else if (!i_cpu_cyc) state <= ARB_IDLE;
        ARB_RX:
          if (i_ram_ack) begin
            o_rx_ptr <= o_rx_ptr == ADR_UL ? ADR_LL : o_rx_ptr + 32'd1;
            state    <= ARB_IDLE;
          end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_ram_arbiter.sv
// tb_uart_ram_arbiter: scoreboard bench with a servant_ram-style RAM model
module tb_uart_ram_arbiter;
  localparam logic [31:0] LL = 32'h00000C00;
  localparam logic [31:0] UL = 32'h00000C03;
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdt;
  } txn_t;
  logic        clk = 0, rst = 1;
  logic [31:0] cpu_adr = 0, cpu_dat = 0;
  logic [3:0]  cpu_sel = 0;
  logic        cpu_we = 0, cpu_cyc = 0;
  logic [31:0] cpu_rdt;
  logic        cpu_ack;
  logic [7:0]  rx_dat = 0;
  logic        rx_valid = 0;
  logic [31:0] ram_adr, ram_dat, ram_rdt = 0;
  logic [3:0]  ram_sel;
  logic        ram_we, ram_cyc, ram_ack = 0, stall = 0;
  logic [31:0] rx_ptr;
  logic [2:0]  rx_level;
  logic        overflow;
  txn_t        exp_q[$];
  int          vectors = 0, miscompares = 0;
  logic [31:0] tb_ptr = LL;
  logic        prev_done = 0, rdt_pending = 0;
  logic [31:0] rdt_exp = 0;
  always #5 clk = ~clk;
  uart_ram_arbiter #(.ADR_LL(LL), .ADR_UL(UL), .FIFO_DEPTH(4)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel), .i_cpu_we(cpu_we),
    .i_cpu_cyc(cpu_cyc), .o_cpu_rdt(cpu_rdt), .o_cpu_ack(cpu_ack),
    .i_rx_dat(rx_dat), .i_rx_valid(rx_valid),
    .o_ram_adr(ram_adr), .o_ram_dat(ram_dat), .o_ram_sel(ram_sel), .o_ram_we(ram_we),
    .o_ram_cyc(ram_cyc), .i_ram_rdt(ram_rdt), .i_ram_ack(ram_ack),
    .o_rx_ptr(rx_ptr), .o_rx_level(rx_level), .o_overflow(overflow)
  );
  function automatic logic [31:0] rdt_of(input logic [31:0] adr);
    return adr == 32'h100 ? 32'hDEADBEEF : {adr[15:0], 16'hA5A5};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // RAM acks one cycle after cyc like servant_ram (ack <= cyc & !ack), unless stalled
  always @(posedge clk) begin
    ram_ack <= ram_cyc & !ram_ack & !stall;
    ram_rdt <= rdt_of(ram_adr);
  end
  // monitor: compare every completed RAM transaction against the scoreboard
  always @(negedge clk) begin : monitor
    txn_t e;
    if (rdt_pending) begin
      chk("cpu_rdt", cpu_rdt, rdt_exp);
      rdt_pending = 0;
    end
    if (prev_done) chk("cyc_gap", ram_cyc, 0);
    prev_done = ram_cyc & ram_ack;
    if (ram_cyc & ram_ack) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_txn: got we=%0b adr=%0h dat=%0h sel=%0h, expected none", ram_we, ram_adr, ram_dat, ram_sel);
      end else begin
        e = exp_q.pop_front();
        chk("ram_txn", {ram_we, ram_adr, ram_dat, ram_sel}, {e.we, e.adr, e.dat, e.sel});
        chk("cpu_ack", cpu_ack, !e.we);
        if (!e.we) begin
          rdt_pending = 1;
          rdt_exp = e.rdt;
        end
      end
    end
  end
  task automatic exp_rx(input logic [7:0] b);
    logic [3:0] s;
    s = 4'b0001 << tb_ptr[1:0];
    exp_q.push_back('{1'b1, tb_ptr, {4{b}}, s, 32'h0});
    tb_ptr = tb_ptr == UL ? LL : tb_ptr + 32'd1;
  endtask
  task automatic exp_cpu(input logic [31:0] adr);
    exp_q.push_back('{1'b0, adr, 32'h0, 4'hF, rdt_of(adr)});
  endtask
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_dat = b; rx_valid = 1;
    @(posedge clk); #1 rx_valid = 0;
  endtask
  task automatic cpu_reads(input logic [31:0] adr, input int n);
    int got = 0;
    cpu_adr = adr; cpu_we = 0; cpu_sel = 4'hF; cpu_dat = 0; cpu_cyc = 1;
    for (int t = 0; t < 400 && got < n; t++) begin
      @(negedge clk);
      if (cpu_ack) got++;
    end
    chk("cpu_ack_count", got, n);
    @(posedge clk); #1 cpu_cyc = 0;
  endtask
  task automatic wait_idle();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && rx_level == 0 && !ram_cyc) break;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1 rst = 0;
    tb_ptr = LL;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ram", {ram_adr, ram_dat, ram_sel, ram_we, ram_cyc}, '0);
    chk("rst_cpu", {cpu_ack, cpu_rdt}, '0);
    chk("rst_ptr", rx_ptr, LL);
    chk("rst_level", rx_level, 0);
    chk("rst_ovf", overflow, 0);
    // CPU read alone
    @(posedge clk); #1;
    exp_cpu(32'h100);
    fork
      cpu_reads(32'h100, 1);
      begin
        @(negedge clk); chk("cyc_before_grant", ram_cyc, 0);
        @(negedge clk); chk("cyc_after_grant", ram_cyc, 1);
      end
    join
    wait_idle();
    chk("rdt_held", cpu_rdt, 32'hDEADBEEF);
    // two RX bytes into the ring
    exp_rx(8'h41); exp_rx(8'h42);
    send_byte(8'h41); send_byte(8'h42);
    wait_idle();
    chk("ptr_after_2", rx_ptr, 32'hC02);
    chk("level_after_2", rx_level, 0);
    // contention: grants alternate CPU, RX, CPU, RX ...
    stall = 1;
    exp_cpu(32'h200); exp_rx(8'h51);
    exp_cpu(32'h200); exp_rx(8'h52);
    exp_cpu(32'h200); exp_rx(8'h53);
    exp_cpu(32'h200);
    fork
      cpu_reads(32'h200, 4);
      begin
        send_byte(8'h51); send_byte(8'h52); send_byte(8'h53);
        @(negedge clk); chk("level_q3", rx_level, 3);
        @(posedge clk); #1 stall = 0;
      end
    join
    wait_idle();
    chk("ptr_after_contention", rx_ptr, 32'hC01);
    // wrap from a fresh reset
    do_reset();
    for (int i = 0; i < 5; i++) exp_rx(8'h71 + 8'(i));
    for (int i = 0; i < 5; i++) send_byte(8'h71 + 8'(i));
    wait_idle();
    chk("ptr_wrap", rx_ptr, 32'hC01);
    chk("ovf_wrap", overflow, 0);
    // overflow while CPU holds a stalled bus
    stall = 1;
    exp_cpu(32'h300);
    for (int i = 0; i < 4; i++) exp_rx(8'h61 + 8'(i));
    fork
      cpu_reads(32'h300, 1);
      begin
        for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
        @(negedge clk);
        chk("level_full", rx_level, 4);
        chk("ovf_set", overflow, 1);
        @(posedge clk); #1 stall = 0;
      end
    join
    wait_idle();
    chk("ovf_sticky", overflow, 1);
    chk("ptr_after_ovf", rx_ptr, 32'hC01);
    // reset during an RX write before ack
    stall = 1;
    send_byte(8'h77);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rx_busy", {ram_cyc, ram_we, ram_adr}, {2'b11, 32'hC01});
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    tb_ptr = LL;
    @(negedge clk);
    chk("rst_mid_cyc", ram_cyc, 0);
    chk("rst_mid_ptr", rx_ptr, LL);
    chk("rst_mid_level", rx_level, 0);
    chk("rst_mid_ovf", overflow, 0);
    @(posedge clk); #1 stall = 0;
    exp_rx(8'h88);
    send_byte(8'h88);
    wait_idle();
    chk("ptr_recover", rx_ptr, 32'hC01);
    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_ram_arbiter.md
Name: uart_ram_arbiter

Overview:
- Shares the single-port servant_ram Wishbone slave between two requesters: the SERV CPU memory bus and a UART RX byte stream.
- Incoming RX bytes are buffered in a small FIFO, then written one byte at a time into a circular RAM window [ADR_LL, ADR_UL].
- Firmware reads the received data from that window.
- Sits between servant (CPU mem bus), uart_rx (byte + done pulse) and servant_ram.

Parameters:
ADR_LL, 32'h00000C00, first byte address of the RX ring window (inclusive)
ADR_UL, 32'h00001FFF, last byte address of the RX ring window (inclusive); must be >= ADR_LL
FIFO_DEPTH, 4, RX byte FIFO entries; power of two, >= 2

Ports:
i_wb_clk  in  1  system clock
i_wb_rst  in  1  synchronous active-high reset
i_cpu_adr  in  32  CPU byte address
i_cpu_dat  in  32  CPU write data
i_cpu_sel  in  4  CPU byte enables
i_cpu_we  in  1  CPU write enable
i_cpu_cyc  in  1  CPU cycle request, held until ack
o_cpu_rdt  out  32  read data to CPU
o_cpu_ack  out  1  single-cycle ack to CPU
i_rx_dat  in  8  received byte
i_rx_valid  in  1  one-cycle strobe: i_rx_dat valid
o_ram_adr  out  32  RAM byte address
o_ram_dat  out  32  RAM write data
o_ram_sel  out  4  RAM byte enables
o_ram_we  out  1  RAM write enable
o_ram_cyc  out  1  RAM cycle
i_ram_rdt  in  32  RAM read data
i_ram_ack  in  1  RAM ack
o_rx_ptr  out  32  next ring address to be written
o_rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_overflow  out  1  sticky: an RX byte was dropped

Behaviour:
- Reset values:
  - state=IDLE, FIFO empty, o_rx_ptr=ADR_LL, o_overflow=0, last_grant=RX.
  - All o_ram_* = 0, o_cpu_ack=0, o_cpu_rdt=0.
- States: IDLE, CPU, RX. o_ram_* are combinational from state; all are 0 in IDLE.
- IDLE arbitration (evaluated every cycle; 1 cycle arbitration latency):
  - cpu_req = i_cpu_cyc; rx_req = FIFO non-empty.
  - Only one requester active -> go to its state.
  - Both active -> grant the requester not in last_grant (round-robin); CPU wins first after reset.
  - On grant, last_grant := the granted requester.
- CPU state:
  - o_ram_* = i_cpu_* passthrough; o_cpu_ack = i_ram_ack; o_cpu_rdt = i_ram_rdt, registered on ack and held.
  - i_ram_ack -> IDLE.
  - i_cpu_cyc dropping before ack -> IDLE immediately, no ack.
- RX state:
  - o_ram_adr = o_rx_ptr, o_ram_dat = {4{fifo_head}}, o_ram_sel = 4'b0001 << o_rx_ptr[1:0], o_ram_we = 1, o_ram_cyc = 1.
  - On i_ram_ack: pop FIFO, advance pointer, go to IDLE.
  - Not abortable except by reset.
- o_cpu_ack is 0 outside CPU state. i_ram_ack outside CPU/RX is ignored.
- Every transaction returns through IDLE, so o_ram_cyc is low for >= 1 cycle between transactions. This is required so servant_ram's ack (cyc & !ack) cannot double-fire.
- Pointer:
  - Advances by 1 per written byte.
  - If o_rx_ptr == ADR_UL, next value is ADR_LL (wrap); compare on the full 32 bits.
- FIFO:
  - i_rx_valid with FIFO not full -> push.
  - i_rx_valid with FIFO full -> byte dropped, o_overflow := 1, held until reset.
  - A simultaneous push and pop on a full FIFO is accepted: the pop frees the slot in the same cycle and no overflow is flagged.
  - o_rx_level reflects registered occupancy.
- Reset mid-transaction:
  - Returns to IDLE and deasserts o_ram_cyc next cycle.
  - Flushes the FIFO; any byte in flight is lost.

Decomposition:
- Shared include/package:
  - State encodings ARB_IDLE=2'd0, ARB_CPU=2'd1, ARB_RX=2'd2.
  - Grant encodings GNT_CPU=1'b0, GNT_RX=1'b1.
- One sub-module: byte_fifo, a synchronous FIFO.
  - Parameter DEPTH.
  - Ports: clk, rst, push, din, pop, dout, full, empty, level.
  - Arbiter FSM, pointer and overflow logic stay in uart_ram_arbiter.

Test Plan:
- CPU read alone: i_cpu_cyc=1, adr=0x100, RAM model acks 1 cycle after cyc with 0xDEADBEEF -> o_ram_cyc rises 1 cycle after request; o_cpu_ack single pulse; o_cpu_rdt=0xDEADBEEF.
- RX bytes 0x41, 0x42 from reset -> RAM writes 0x41 to 0xC00 with sel=0001, then 0x42 to 0xC01 with sel=0010; o_rx_ptr ends at 0xC02; o_rx_level returns to 0.
- Contention: CPU cyc held continuously while 3 RX bytes are queued -> grants alternate CPU, RX, CPU, RX, ...; o_ram_cyc low for one cycle between each grant; no CPU ack lost.
- Wrap: ADR_UL=0xC03, push 5 bytes -> writes to 0xC00..0xC03, then 0xC00; final o_rx_ptr=0xC01.
- Overflow: CPU holds bus with a stalled RAM ack, push FIFO_DEPTH+1=5 bytes -> o_rx_level=4; o_overflow=1 and stays 1; only the first 4 bytes reach RAM.
- Reset during RX write (before ack) -> next cycle o_ram_cyc=0; o_rx_ptr=ADR_LL; o_rx_level=0; o_overflow=0.
